// File: rtl/traffic_phase_ctrl_if.sv
// rtl/traffic_phase_ctrl_if.sv - control and lamp bundle between the time-base side and traffic_phase_ctrl
interface traffic_phase_ctrl_if #(
  parameter int NUM_DIR = 2,
  parameter int CNT_W   = 16
);
  localparam int DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

  logic               EN;
  logic               TICK;
  logic               LOAD;
  logic [CNT_W-1:0]   SETGREEN;
  logic [CNT_W-1:0]   SETYELLOW;
  logic [NUM_DIR-1:0] REQ;
  logic [NUM_DIR-1:0] RED;
  logic [NUM_DIR-1:0] YELLOW;
  logic [NUM_DIR-1:0] GREEN;
  logic [DIR_W-1:0]   ACTIVE_DIR;
  logic [CNT_W-1:0]   REMAIN;

  modport master (
    output EN, TICK, LOAD, SETGREEN, SETYELLOW, REQ,
    input  RED, YELLOW, GREEN, ACTIVE_DIR, REMAIN
  );

  modport slave (
    input  EN, TICK, LOAD, SETGREEN, SETYELLOW, REQ,
    output RED, YELLOW, GREEN, ACTIVE_DIR, REMAIN
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - round-robin traffic phase controller; define TRAFFIC_SKIP_EN to skip approaches without demand
module traffic_phase_ctrl #(
  parameter int NUM_DIR     = 2,
  parameter int CNT_W       = 16,
  parameter int GREEN_TIME  = 25,
  parameter int YELLOW_TIME = 5,
  parameter int ALLRED_TIME = 2
) (
  input logic                 CLK,
  input logic                 RSTN,
  traffic_phase_ctrl_if.slave bus
);
  localparam int DIR_W = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1;

  localparam logic [1:0] ST_GREEN  = 2'd0;
  localparam logic [1:0] ST_YELLOW = 2'd1;
  localparam logic [1:0] ST_ALLRED = 2'd2;

  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIR - 1);

  logic [1:0]         state, state_nx;
  logic [DIR_W-1:0]   dir, dir_nx;
  logic [CNT_W-1:0]   remain, remain_nx;
  logic [CNT_W-1:0]   green_dur, yellow_dur;
  logic [NUM_DIR-1:0] sel_nx;
  logic               step;
  logic               next_ok;
  logic [DIR_W-1:0]   next_dir;

  assign step   = bus.EN & bus.TICK;
  assign sel_nx = NUM_DIR'(1) << dir_nx;

  assign bus.ACTIVE_DIR = dir;
  assign bus.REMAIN     = remain;

  // a zero duration would make the phase vanish, so it is treated as one tick
  function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

`ifdef TRAFFIC_SKIP_EN
  logic [DIR_W-1:0] idx;

  // first requesting approach after the current one, wrapping back to itself last
  always_comb begin
    next_ok  = 1'b0;
    next_dir = dir;
    idx      = dir;
    for (int i = 1; i <= NUM_DIR; i++) begin
      idx = DIR_W'((int'(dir) + i) % NUM_DIR);
      if (!next_ok && bus.REQ[idx]) begin
        next_ok  = 1'b1;
        next_dir = idx;
      end
    end
  end
`else
  logic unused_req;
  assign unused_req = ^bus.REQ;

  // strict round-robin successor
  always_comb begin
    next_ok  = 1'b1;
    next_dir = (dir == LAST_DIR) ? '0 : dir + DIR_W'(1);
  end
`endif

  // phase transitions and countdown, advancing only on enabled time-base strobes
  always_comb begin
    state_nx  = state;
    dir_nx    = dir;
    remain_nx = remain;
    if (step) begin
      if (remain != '0) begin
        remain_nx = remain - CNT_W'(1);
      end else begin
        case (state)
          ST_GREEN: begin
            state_nx  = ST_YELLOW;
            remain_nx = yellow_dur - CNT_W'(1);
          end
          ST_YELLOW: begin
            state_nx  = ST_ALLRED;
            remain_nx = CNT_W'(ALLRED_TIME - 1);
          end
          ST_ALLRED: begin
            if (next_ok) begin
              state_nx  = ST_GREEN;
              dir_nx    = next_dir;
              remain_nx = green_dur - CNT_W'(1);
            end
          end
          default: begin
            state_nx  = ST_ALLRED;
            remain_nx = CNT_W'(ALLRED_TIME - 1);
          end
        endcase
      end
    end
  end

  // phase state registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state  <= ST_ALLRED;
      dir    <= LAST_DIR;
      remain <= CNT_W'(ALLRED_TIME - 1);
    end else begin
      state  <= state_nx;
      dir    <= dir_nx;
      remain <= remain_nx;
    end
  end

  // shadow durations; entries read the value held before this edge's LOAD
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      green_dur  <= CNT_W'(GREEN_TIME);
      yellow_dur <= CNT_W'(YELLOW_TIME);
    end else if (bus.LOAD) begin
      green_dur  <= clamp1(bus.SETGREEN);
      yellow_dur <= clamp1(bus.SETYELLOW);
    end
  end

  // registered lamps decoded from the next phase so they line up with state
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      bus.RED    <= '1;
      bus.YELLOW <= '0;
      bus.GREEN  <= '0;
    end else begin
      bus.GREEN  <= (state_nx == ST_GREEN) ? sel_nx : '0;
      bus.YELLOW <= (state_nx == ST_YELLOW) ? sel_nx : '0;
      bus.RED    <= (state_nx == ST_GREEN || state_nx == ST_YELLOW) ? ~sel_nx : '1;
    end
  end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - scoreboard bench for traffic_phase_ctrl
`timescale 1ns/1ps
module tb_traffic_phase_ctrl;
  localparam int ND = 4;
  localparam int CW = 16;
  localparam logic [1:0] K_G = 2'd0;
  localparam logic [1:0] K_Y = 2'd1;
  localparam logic [1:0] K_R = 2'd2;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  traffic_phase_ctrl_if #(.NUM_DIR(ND), .CNT_W(CW)) bus ();
  traffic_phase_ctrl #(.NUM_DIR(ND), .CNT_W(CW)) dut (.CLK(clk), .RSTN(rstn), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];
  int tick_div = 1;
  int cyc = 0;
  int n;

  function automatic logic [31:0] ph(input logic [1:0] k, input int d, input int t);
    return {2'b00, k, 4'(d), 8'h00, 16'(t)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    bus.TICK = (cyc % tick_div == 0);
  endtask

  task automatic run(input int cnt);
    for (int i = 0; i < cnt; i++) cycle();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    bus.EN = 1'b0;
    bus.LOAD = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc = 0;
    bus.EN = 1'b1;
    bus.TICK = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_red"}, 32'(bus.RED), 32'hF);
    chk({tag, "_yellow"}, 32'(bus.YELLOW), 32'h0);
    chk({tag, "_green"}, 32'(bus.GREEN), 32'h0);
    chk({tag, "_dir"}, 32'(bus.ACTIVE_DIR), 32'd3);
    chk({tag, "_remain"}, 32'(bus.REMAIN), 32'd1);
  endtask

  // phase monitor: measures strobes per displayed phase and checks lamp invariants
  logic       in_ph = 1'b0;
  logic [5:0] mon_kd;
  int         mon_cnt = 0;
  always @(negedge clk) begin : mon
    logic [1:0] k;
    int d;
    int nonred;
    if (!rstn) begin
      in_ph = 1'b0;
    end else begin
      nonred = 0;
      k = K_R;
      d = int'(bus.ACTIVE_DIR);
      for (int i = 0; i < ND; i++) begin
        chk("lamp_onehot", 32'($countones({bus.RED[i], bus.YELLOW[i], bus.GREEN[i]})), 32'd1);
        if (!bus.RED[i]) begin
          nonred++;
          d = i;
          k = bus.GREEN[i] ? K_G : K_Y;
        end
      end
      chk("single_nonred", 32'(nonred <= 1), 32'd1);
      if (k != K_R) chk("active_dir_match", 32'(bus.ACTIVE_DIR), 32'(d));
      if (!in_ph) begin
        mon_kd = {k, 4'(d)};
        mon_cnt = 0;
        in_ph = 1'b1;
      end else if ({k, 4'(d)} != mon_kd) begin
        if (sb.size() == 0)
          chk("phase_unexpected", ph(mon_kd[5:4], int'(mon_kd[3:0]), mon_cnt), 32'hFFFF_FFFF);
        else
          chk("phase", ph(mon_kd[5:4], int'(mon_kd[3:0]), mon_cnt), sb.pop_front());
        mon_kd = {k, 4'(d)};
        mon_cnt = 0;
      end
      if (bus.EN && bus.TICK) mon_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.EN = 1'b0;
    bus.TICK = 1'b0;
    bus.LOAD = 1'b0;
    bus.SETGREEN = '0;
    bus.SETYELLOW = '0;
    bus.REQ = '1;

    // full round-robin cycle with a tick every clock, wrapping 3 -> 0
    do_reset();
    check_reset_outputs("rst");
    sb.push_back(ph(K_R, 3, 2));
    for (int d = 0; d < ND; d++) begin
      sb.push_back(ph(K_G, d, 25));
      sb.push_back(ph(K_Y, d, 5));
      sb.push_back(ph(K_R, d, 2));
    end
    sb.push_back(ph(K_G, 0, 25));
    run(157);
    chk("drain_rr", 32'(sb.size()), 32'd0);

    // sparse ticks, freeze with EN=0 at REMAIN=10, then resume
    do_reset();
    tick_div = 4;
    sb.push_back(ph(K_R, 3, 2));
    sb.push_back(ph(K_G, 0, 25));
    sb.push_back(ph(K_Y, 0, 5));
    n = 0;
    while ((bus.REMAIN != 16'd10 || bus.GREEN != 4'b0001) && n < 500) begin
      cycle();
      n++;
    end
    chk("reach_rem10", 32'(n < 500), 32'd1);
    bus.EN = 1'b0;
    tick_div = 1;
    bus.TICK = 1'b1;
    run(25);
    chk("frozen_remain_mid", 32'(bus.REMAIN), 32'd10);
    run(25);
    chk("frozen_remain", 32'(bus.REMAIN), 32'd10);
    chk("frozen_green", 32'(bus.GREEN), 32'h1);
    chk("frozen_red", 32'(bus.RED), 32'hE);
    bus.EN = 1'b1;
    n = 0;
    while (!bus.YELLOW[0] && n < 40) begin
      cycle();
      n++;
    end
    chk("ticks_to_yellow", 32'(n), 32'd11);
    run(6);
    chk("drain_freeze", 32'(sb.size()), 32'd0);

    // shadow load mid-green with yellow clamp, then async reset mid-yellow
    do_reset();
    sb.push_back(ph(K_R, 3, 2));
    sb.push_back(ph(K_G, 0, 25));
    sb.push_back(ph(K_Y, 0, 1));
    sb.push_back(ph(K_R, 0, 2));
    sb.push_back(ph(K_G, 1, 3));
    sb.push_back(ph(K_Y, 1, 1));
    sb.push_back(ph(K_R, 1, 2));
    sb.push_back(ph(K_G, 2, 3));
    run(10);
    bus.SETGREEN = 16'd3;
    bus.SETYELLOW = 16'd0;
    bus.LOAD = 1'b1;
    cycle();
    bus.LOAD = 1'b0;
    n = 0;
    while (!bus.YELLOW[2] && n < 200) begin
      cycle();
      n++;
    end
    chk("reach_y2", 32'(n < 200), 32'd1);
    #7;
    chk("pre_reset_yellow", 32'(bus.YELLOW), 32'h4);
    chk("drain_load", 32'(sb.size()), 32'd0);
    bus.EN = 1'b0;
    rstn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    #9;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    bus.EN = 1'b1;
    bus.TICK = 1'b1;
    sb.push_back(ph(K_R, 3, 2));
    sb.push_back(ph(K_G, 0, 25));
    sb.push_back(ph(K_Y, 0, 5));
    run(33);
    chk("drain_async", 32'(sb.size()), 32'd0);

    // LOAD on the same edge as entry into yellow: entry keeps the old value
    do_reset();
    sb.push_back(ph(K_R, 3, 2));
    sb.push_back(ph(K_G, 0, 25));
    sb.push_back(ph(K_Y, 0, 5));
    sb.push_back(ph(K_R, 0, 2));
    sb.push_back(ph(K_G, 1, 7));
    sb.push_back(ph(K_Y, 1, 2));
    sb.push_back(ph(K_R, 1, 2));
    n = 0;
    while (!(bus.GREEN[0] && bus.REMAIN == 16'd0) && n < 100) begin
      cycle();
      n++;
    end
    chk("reach_g0_end", 32'(n < 100), 32'd1);
    bus.SETGREEN = 16'd7;
    bus.SETYELLOW = 16'd2;
    bus.LOAD = 1'b1;
    cycle();
    bus.LOAD = 1'b0;
    chk("entry_old_yellow", 32'(bus.REMAIN), 32'd4);
    run(19);
    chk("drain_simul", 32'(sb.size()), 32'd0);

`ifdef TRAFFIC_SKIP_EN
    // demand skipping: 0 -> 3, hold all-red without demand, then 1
    bus.REQ = 4'b0001;
    do_reset();
    sb.push_back(ph(K_R, 3, 2));
    sb.push_back(ph(K_G, 0, 25));
    sb.push_back(ph(K_Y, 0, 5));
    sb.push_back(ph(K_R, 0, 2));
    sb.push_back(ph(K_G, 3, 25));
    sb.push_back(ph(K_Y, 3, 5));
    sb.push_back(ph(K_R, 3, 11));
    sb.push_back(ph(K_G, 1, 25));
    run(3);
    bus.REQ = 4'b1000;
    n = 0;
    while (!bus.YELLOW[3] && n < 200) begin
      cycle();
      n++;
    end
    chk("reach_y3", 32'(n < 200), 32'd1);
    bus.REQ = 4'b0000;
    n = 0;
    while (bus.RED != 4'hF && n < 20) begin
      cycle();
      n++;
    end
    chk("reach_allred", 32'(n < 20), 32'd1);
    run(10);
    chk("hold_allred", 32'(bus.RED), 32'hF);
    chk("hold_remain", 32'(bus.REMAIN), 32'd0);
    bus.REQ = 4'b0010;
    cycle();
    chk("skip_to_dir1", 32'(bus.GREEN), 32'h2);
    run(26);
    chk("drain_skip", 32'(sb.size()), 32'd0);
    bus.REQ = '1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
Parametrised multi-approach traffic light controller that sequences NUM_DIR approaches round-robin.
- Per active approach: GREEN -> YELLOW -> ALL-RED clearance; every other approach is held red.
- Counting advances on an external time-base strobe, not on every clock.
- Green and yellow durations are reprogrammable at runtime through shadow registers.
- Sits between the system time-base divider and the lamp drivers.

Parameters:
NUM_DIR, 2, number of approaches (2..8)
CNT_W, 16, width of phase counter and duration inputs
GREEN_TIME, 25, reset value of green duration (ticks)
YELLOW_TIME, 5, reset value of yellow duration (ticks)
ALLRED_TIME, 2, all-red clearance duration (ticks), fixed, must be >=1

Ports:
CLK  in  1  clock
RSTN  in  1  asynchronous active-low reset
EN  in  1  run enable; 0 freezes state, counter and lamps
TICK  in  1  one-cycle time-base strobe; counter only moves when EN=1 and TICK=1
LOAD  in  1  one-cycle strobe; captures SETGREEN/SETYELLOW into shadow registers
SETGREEN  in  CNT_W  new green duration (ticks)
SETYELLOW  in  CNT_W  new yellow duration (ticks)
REQ  in  NUM_DIR  per-approach demand; used only with TRAFFIC_SKIP_EN
RED  out  NUM_DIR  red lamp per approach
YELLOW  out  NUM_DIR  yellow lamp per approach
GREEN  out  NUM_DIR  green lamp per approach
ACTIVE_DIR  out  DIR_W  approach currently owning the phase; DIR_W = max(1, clog2(NUM_DIR))
REMAIN  out  CNT_W  ticks left in current phase, minus 1

Behaviour:
- Reset (RSTN=0, asynchronous):
  - state=ALLRED, RED=all 1, YELLOW=0, GREEN=0.
  - ACTIVE_DIR=NUM_DIR-1, REMAIN=ALLRED_TIME-1.
  - Shadow regs: green=GREEN_TIME, yellow=YELLOW_TIME.
  - Outputs are registered; the first green after reset goes to approach 0.
- States and transitions:
  - GREEN -> YELLOW -> ALLRED -> GREEN (next approach).
  - A transition occurs on a clock edge with EN=1, TICK=1 and REMAIN==0.
  - On entry to a state, REMAIN is loaded with that state's duration-1.
  - Otherwise, on EN&TICK, REMAIN decrements by 1. No wrap: REMAIN never decrements below 0.
- ALLRED -> GREEN: ACTIVE_DIR advances by 1, modulo NUM_DIR (NUM_DIR-1 wraps to 0).
- Lamp outputs:
  - Active approach: GREEN or YELLOW bit set per state, RED bit clear.
  - All other approaches: RED=1.
  - In ALLRED, all RED=1.
  - Invariant, every cycle: per approach exactly one of R/Y/G is set, and at most one approach is non-red.
- Phase duration: a phase lasts exactly its duration in TICKs (duration N -> N strobes).
- Shadow registers:
  - LOAD captures SETGREEN/SETYELLOW in the same cycle, regardless of EN.
  - A value of 0 is clamped to 1.
  - New values take effect only at the next entry into the corresponding state; a running phase is never shortened or extended.
- Simultaneous events:
  - LOAD in the same cycle as entry to GREEN/YELLOW: the entry uses the OLD shadow value.
  - TICK with EN=0: ignored; strobes are not queued.
- Reset mid-phase: immediate return to the reset state; shadow registers revert to parameter values.

Optional Feature:
TRAFFIC_SKIP_EN
- Defined:
  - ALLRED -> GREEN selects the next approach in round-robin order, starting from ACTIVE_DIR+1, whose REQ bit is 1.
  - If no REQ bit is set, the controller stays in ALLRED. REMAIN holds at 0, re-evaluated every EN&TICK.
  - REQ is sampled only at that transition edge.
- Undefined: REQ is ignored and every approach is served in strict round-robin order.

Test Plan:
- Reset, EN=1, TICK every cycle, NUM_DIR=2, defaults -> 2 cycles all red; dir0 green 25 cycles; yellow 5; all red 2; then dir1 green. ACTIVE_DIR 0 -> 1 -> 0 wraps.
- NUM_DIR=4, TICK every 4th cycle -> green phase lasts 100 clocks. Sequence 0,1,2,3,0. Invariant checker holds every cycle.
- Mid-green of dir0 at REMAIN=10: EN=0 for 50 cycles with TICKs -> lamps and REMAIN frozen at 10. Resume -> 11 further ticks to yellow.
- LOAD SETGREEN=3, SETYELLOW=0 during dir0 green:
  - Dir0 green completes its 25 ticks.
  - Dir0 yellow lasts 1 tick (clamped).
  - Dir1 green lasts 3 ticks.
- RSTN pulse low for 1 cycle mid-yellow (asynchronous, not clock-aligned) -> outputs all red immediately; shadow regs back to 25/5; next green is dir0.
- TRAFFIC_SKIP_EN, NUM_DIR=4, REQ=4'b1000 after dir0 -> dir3 green next. With REQ=0 -> stays ALLRED; asserting REQ[1] -> dir1 green on the next tick.
